sirv_uart_tx: RTL and testbench
===============================

SIRV_UART_TX -- requirements
Module: sirv_uart_tx

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port: io_en  input  1  transmit enable; gates acceptance of new bytes only.
REQ-004 SHALL have port: io_in_valid  input  1  byte available from the upstream 8-entry byte queue (dequeue side).
REQ-005 SHALL have port: io_in_ready  output  1  block accepts the byte this cycle.
REQ-006 SHALL have port: io_in_bits  input  8  byte to transmit.
REQ-007 SHALL have port: io_div  input  16  baud divisor; each bit lasts io_div+1 clock cycles.
REQ-008 SHALL have port: io_nstop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port: io_out  output  1  serial line, idle high.
REQ-010 SHALL have port: io_busy  output  1  a frame is in progress.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, STOP, plus PARITY when SIRV_UART_TX_PARITY_EN is defined.
REQ-012 SHALL drive io_in_ready = (state==IDLE) & io_en, combinationally, with no dependency on io_in_valid.
REQ-013 SHALL accept a byte when io_in_valid & io_in_ready: latch io_in_bits, io_div and io_nstop into internal registers, and enter START on the next edge.
REQ-014 SHALL use the latched divisor, latched stop count and latched byte for the whole frame; input changes mid-frame have no effect.
REQ-015 SHALL count bit time with a 16-bit down-counter loaded with the latched divisor at each bit start, advancing to the next bit when the counter reaches 0. Each bit lasts exactly div+1 cycles; io_div=0 gives 1 cycle per bit.
REQ-016 SHALL drive io_out: START = 0; DATA = byte bits 0..7, LSB first, tracked by a 3-bit bit index; STOP = 1 for one or two bit times; IDLE = 1.
REQ-017 SHALL move from DATA to STOP (or to PARITY when built in) after bit index 7 completes.
REQ-018 SHALL return to IDLE after the last stop bit time; io_in_ready may reassert in the first IDLE cycle, so the gap between back-to-back frames is 1 idle cycle.
REQ-019 SHALL drive io_busy = (state != IDLE).
REQ-020 SHALL complete an in-progress frame when io_en falls mid-frame; io_en only blocks the next acceptance.
REQ-021 SHALL hold io_in_ready low during a frame regardless of io_in_valid, so the upstream queue is never dequeued mid-frame.

Reset
REQ-022 SHALL on reset force state=IDLE, io_out=1, io_busy=0, counter=0 and bit index=0, taking effect at the first rising edge with reset high.
REQ-023 SHALL on reset mid-frame abort the frame without finishing it, drive io_out high from the next cycle and leave the byte unsent.
REQ-024 SHALL leave the latched byte register unreset (don't-care).

Configuration
REQ-025 SHALL, with SIRV_UART_TX_PARITY_EN defined, add input io_parity (1 bit, 0 = even, 1 = odd), latch it at acceptance, and insert one PARITY bit between DATA and STOP whose value is XOR of the 8 data bits XOR the latched io_parity.
REQ-026 SHALL, without SIRV_UART_TX_PARITY_EN defined, have no io_parity port and no PARITY state, giving a frame of 10 or 11 bits.

Verification
REQ-027 SHALL cover: div=3, nstop=0, byte 0xA5 -> io_out 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; io_busy high 40 cycles.
REQ-028 SHALL cover: div=0, nstop=1, byte 0x00 -> 1-cycle start, 8 low data cycles, 2 high stop cycles; frame is 11 cycles.
REQ-029 SHALL cover: valid held high with bytes 0x55 then 0x0F, div=1 -> exactly 2 handshakes, frames separated by exactly 1 idle cycle with io_out=1.
REQ-030 SHALL cover: io_en dropped during DATA of byte 0x3C -> frame completes unchanged; io_in_ready stays 0 until io_en=1.
REQ-031 SHALL cover: reset asserted during bit 4 of 0xFF -> next cycle io_out=1, io_busy=0, io_in_ready=io_en.
REQ-032 SHALL cover: with SIRV_UART_TX_PARITY_EN defined, io_parity=0, byte 0x07 -> parity bit 1; with io_parity=1 -> parity bit 0.

Source files
------------

// File: rtl/sirv_uart_tx.sv
// sirv_uart_tx: 8-bit UART transmitter, LSB first, start bit, 1 or 2 stop bits, programmable baud divisor.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   io_en        transmit enable; gates acceptance of new bytes only
//   io_in_valid  upstream byte available
//   io_in_ready  byte accepted this cycle (IDLE and enabled)
//   io_in_bits   byte to transmit
//   io_div       baud divisor; each bit lasts io_div+1 cycles
//   io_nstop     0 = one stop bit, 1 = two stop bits
//   io_parity    (SIRV_UART_TX_PARITY_EN only) 0 = even, 1 = odd parity
//   io_out       serial line, idle high
//   io_busy      frame in progress
// Optional feature: define SIRV_UART_TX_PARITY_EN to insert a parity bit between data and stop.
module sirv_uart_tx (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_en,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits,
  input  logic [15:0] io_div,
  input  logic        io_nstop,
`ifdef SIRV_UART_TX_PARITY_EN
  input  logic        io_parity,
`endif
  output logic        io_out,
  output logic        io_busy
);
`ifdef SIRV_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t      r_state;
  logic [7:0]  r_byte;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic        r_nstop;
  logic        r_stop2;
  logic        r_out;
`ifdef SIRV_UART_TX_PARITY_EN
  logic        r_par;
`endif
  logic        w_fire;
  logic        w_tick;
  logic [2:0]  w_nidx;
  assign io_in_ready = (r_state == IDLE) & io_en;
  assign io_busy     = r_state != IDLE;
  assign io_out      = r_out;
  assign w_fire      = io_in_valid & io_in_ready;
  // A bit time ends on the cycle the down-counter sits at zero.
  assign w_tick      = r_cnt == 16'd0;
  assign w_nidx      = r_idx + 3'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= 1'b1;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_div   <= 16'd0;
      r_nstop <= 1'b0;
      r_stop2 <= 1'b0;
`ifdef SIRV_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_byte  <= io_in_bits;
            r_div   <= io_div;
            r_nstop <= io_nstop;
`ifdef SIRV_UART_TX_PARITY_EN
            r_par   <= io_parity;
`endif
            r_cnt   <= io_div;
            r_idx   <= 3'd0;
            r_stop2 <= 1'b0;
            r_out   <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_cnt   <= r_div;
            r_out   <= r_byte[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt <= r_div;
            if (r_idx == 3'd7) begin
              r_idx   <= 3'd0;
`ifdef SIRV_UART_TX_PARITY_EN
              r_out   <= ^r_byte ^ r_par;
              r_state <= PARITY;
`else
              r_out   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_idx <= w_nidx;
              r_out <= r_byte[w_nidx];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef SIRV_UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_cnt   <= r_div;
            r_out   <= 1'b1;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          // Second stop bit reloads the counter and stays in STOP with the line high.
          if (w_tick) begin
            if (r_nstop && !r_stop2) begin
              r_stop2 <= 1'b1;
              r_cnt   <= r_div;
            end else begin
              r_out   <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_out   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sirv_uart_tx.sv
// tb_sirv_uart_tx: table-driven and hand-written frame scenarios checked against a per-cycle serial waveform scoreboard.
module tb_sirv_uart_tx;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_en = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [7:0]  io_in_bits = 8'h00;
  logic [15:0] io_div = 16'd0;
  logic        io_nstop = 1'b0;
  logic        io_parity = 1'b0;
  logic        io_out;
  logic        io_busy;

  always #5 clock = ~clock;

  sirv_uart_tx dut (
    .clock(clock),
    .reset(reset),
    .io_en(io_en),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_bits(io_in_bits),
    .io_div(io_div),
    .io_nstop(io_nstop),
`ifdef SIRV_UART_TX_PARITY_EN
    .io_parity(io_parity),
`endif
    .io_out(io_out),
    .io_busy(io_busy)
  );

  typedef struct {
    logic [7:0]  b;
    logic [15:0] d;
    logic        n;
    logic        p;
  } frame_t;

  localparam int NV = 8;
  frame_t tv [NV];
  frame_t sb_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs = 0;
  int last_gap = -1;
  int end_cyc = 0;
  int frames_done = 0;
  logic mon_active = 1'b0;
  logic mon_post = 1'b0;
  logic mon_wave [$];
  int mon_idx = 0;
  int mon_bad = -1;
  logic mon_got_out, mon_got_busy, mon_want;
  logic [7:0] mon_byte;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout", name);
  endtask

  // Expected line level for every cycle of a frame.
  task automatic load_wave(input frame_t f);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.b[i]);
`ifdef SIRV_UART_TX_PARITY_EN
    bits.push_back((^f.b) ^ f.p);
`endif
    bits.push_back(1'b1);
    if (f.n) bits.push_back(1'b1);
    mon_wave.delete();
    foreach (bits[k])
      for (int r = 0; r <= int'(f.d); r++) mon_wave.push_back(bits[k]);
  endtask

  always @(posedge clock)
    if (!reset && io_in_valid && io_in_ready) hs++;

  // Monitor: pops the expected frame when busy rises and compares io_out cycle by cycle.
  initial begin
    frame_t f;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset) begin
        mon_active = 1'b0;
        mon_post = 1'b0;
        sb_q.delete();
      end else begin
        if (mon_post) begin
          mon_post = 1'b0;
          chk("frame_gap_busy_out", {30'd0, io_busy, io_out}, 32'h1);
        end
        if (!mon_active && io_busy) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            f = sb_q.pop_front();
            load_wave(f);
            mon_byte = f.b;
            mon_active = 1'b1;
            mon_idx = 0;
            mon_bad = -1;
            last_gap = cyc - end_cyc - 1;
          end
        end
        if (mon_active) begin
          if (mon_bad < 0 && (io_out !== mon_wave[mon_idx] || io_busy !== 1'b1)) begin
            mon_bad = mon_idx;
            mon_got_out = io_out;
            mon_got_busy = io_busy;
            mon_want = mon_wave[mon_idx];
          end
          mon_idx++;
          if (mon_idx == mon_wave.size()) begin
            checks++;
            if (mon_bad >= 0) begin
              failures++;
              $display("FAIL frame_wave byte=%h cycle=%0d got out=%b busy=%b want out=%b busy=1",
                       mon_byte, mon_bad, mon_got_out, mon_got_busy, mon_want);
            end
            mon_active = 1'b0;
            mon_post = 1'b1;
            end_cyc = cyc;
            frames_done++;
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (io_in_ready !== 1'b1) begin
      @(negedge clock);
      n++;
      if (n > 500) begin
        fail_now(name);
        return;
      end
    end
  endtask

  // Waits for the frame to finish while scrambling the inputs to prove they were latched.
  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      io_in_bits = 8'($urandom);
      io_div = 16'($urandom_range(0, 7));
      io_nstop = 1'($urandom);
      io_parity = 1'($urandom);
      n++;
      if (n > 2000) begin
        fail_now(name);
        return;
      end
    end while (io_busy !== 1'b0 || mon_active || mon_post);
  endtask

  task automatic drive(input frame_t f);
    io_in_bits = f.b;
    io_div = f.d;
    io_nstop = f.n;
    io_parity = f.p;
    io_in_valid = 1'b1;
    sb_q.push_back(f);
  endtask

  task automatic send(input frame_t f);
    drive(f);
    wait_ready("send_ready");
    @(negedge clock);
    io_in_valid = 1'b0;
    wait_idle("send_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int h0, cnt;
    tv[0] = '{8'hA5, 16'd3, 1'b0, 1'b0};
    tv[1] = '{8'h00, 16'd0, 1'b1, 1'b0};
    tv[2] = '{8'hFF, 16'd2, 1'b1, 1'b0};
    tv[3] = '{8'h81, 16'd5, 1'b0, 1'b1};
    tv[4] = '{8'h07, 16'd1, 1'b0, 1'b0};
    tv[5] = '{8'h07, 16'd1, 1'b0, 1'b1};
    tv[6] = '{8'h3C, 16'd0, 1'b0, 1'b0};
    tv[7] = '{8'hC3, 16'd4, 1'b1, 1'b1};
    repeat (3) @(negedge clock);
    chk("reset_out", {31'd0, io_out}, 32'd1);
    chk("reset_busy", {31'd0, io_busy}, 32'd0);
    chk("reset_ready_en0", {31'd0, io_in_ready}, 32'd0);
    io_en = 1'b1;
    #1;
    chk("reset_ready_en1", {31'd0, io_in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NV; i++) send(tv[i]);
    // Back-to-back frames with valid held high.
    h0 = hs;
    drive('{8'h55, 16'd1, 1'b0, 1'b0});
    sb_q.push_back('{8'h0F, 16'd1, 1'b0, 1'b0});
    wait_ready("b2b_ready1");
    @(negedge clock);
    io_in_bits = 8'h0F;
    wait_ready("b2b_ready2");
    @(negedge clock);
    io_in_valid = 1'b0;
    wait_idle("b2b_idle");
    chk("b2b_handshakes", hs - h0, 32'd2);
    chk("b2b_idle_gap", last_gap, 32'd1);
    // io_en dropped during DATA: frame completes, no new acceptance.
    drive('{8'h3C, 16'd2, 1'b0, 1'b0});
    wait_ready("en_ready");
    repeat (6) @(negedge clock);
    io_en = 1'b0;
    io_in_bits = 8'h99;
    h0 = hs;
    cnt = 0;
    for (int n = 0; n < 200 && (io_busy !== 1'b0 || mon_active || mon_post); n++) begin
      @(negedge clock);
      if (io_in_ready !== 1'b0) cnt++;
    end
    repeat (10) begin
      @(negedge clock);
      if (io_in_ready !== 1'b0) cnt++;
    end
    chk("en_low_ready", cnt, 32'd0);
    chk("en_low_handshakes", hs - h0, 32'd0);
    chk("en_low_busy", {31'd0, io_busy}, 32'd0);
    io_in_valid = 1'b0;
    io_en = 1'b1;
    #1;
    chk("en_back_ready", {31'd0, io_in_ready}, 32'd1);
    @(negedge clock);
    // Reset during data bit 4 of 0xFF aborts the frame.
    drive('{8'hFF, 16'd3, 1'b0, 1'b0});
    wait_ready("rst_ready");
    @(negedge clock);
    io_in_valid = 1'b0;
    repeat (20) @(negedge clock);
    chk("rst_pre_busy", {31'd0, io_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_out", {31'd0, io_out}, 32'd1);
    chk("rst_busy", {31'd0, io_busy}, 32'd0);
    chk("rst_ready", {31'd0, io_in_ready}, {31'd0, io_en});
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clock);
      if (io_out !== 1'b1 || io_busy !== 1'b0) cnt++;
    end
    chk("rst_no_resume", cnt, 32'd0);
    f = '{8'h5A, 16'd1, 1'b1, 1'b0};
    send(f);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    chk("frames_done", frames_done, NV + 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
